// File: rtl/lsu_mem_stage.sv
// Load/store unit for the execute->memory path.
//
// The ALU result is used as the effective byte address. The unit drives a word-wide
// data-memory port with byte enables and a request/acknowledge handshake. Load data
// comes back aligned and sign- or zero-extended, and stall stays high while an op is
// in flight.
//
// Ports:
//   clk, reset_n        core clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready op handshake; req_ready is high only in IDLE
//   op                  [3]=store, [2]=unsigned load, [1:0]=size (byte/half/word/invalid)
//   addr, wdata         effective byte address and store data (value in the low bits)
//   mem_req/mem_ack     memory handshake; mem_req is held until mem_ack
//   mem_we, mem_addr    write enable and word-aligned address
//   mem_be, mem_wdata   little-endian byte enables and lane-replicated store data
//   mem_rdata           read word, valid together with mem_ack
//   rd_valid, rdata     one-cycle writeback pulse; rdata holds until the next load
//   stall               high whenever the FSM is not in IDLE
//   misalign            one-cycle exception pulse (only with LSU_MISALIGN_EXC_EN)
//
// Optional feature, macro LSU_MISALIGN_EXC_EN:
//   Defined:   a misaligned op is accepted, issues no memory request and pulses
//              misalign for one cycle.
//   Undefined: the offending low address bits are cleared and the access proceeds.
module lsu_mem_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              stall
`ifdef LSU_MISALIGN_EXC_EN
  ,
  output logic              misalign
`endif
);

`ifdef LSU_MISALIGN_EXC_EN
  localparam bit MisalExc = 1'b1;
`else
  localparam bit MisalExc = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e state_q, state_d;

  logic              we_q, uns_q, miss_q;
  logic [1:0]        size_q, lane_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  // Decode of the incoming op, used only on the accept cycle
  logic              accept, misal_in;
  logic [1:0]        size_in, lane_in;
  logic [3:0]        be_in;
  logic [DATA_W-1:0] wdata_in;

  always_comb begin
    size_in  = op[1:0];
    accept   = req_valid && (state_q == StIdle) && (size_in != 2'b11);
    misal_in = ((size_in == 2'b01) && addr[0]) ||
               ((size_in == 2'b10) && (addr[1:0] != 2'b00));
    // Misaligned offsets are rounded down to the natural boundary of the access
    case (size_in)
      2'b01:   lane_in = {addr[1], 1'b0};
      2'b10:   lane_in = 2'b00;
      default: lane_in = addr[1:0];
    endcase
    case (size_in)
      2'b00:   be_in = 4'b0001 << lane_in;
      2'b01:   be_in = lane_in[1] ? 4'b1100 : 4'b0011;
      2'b10:   be_in = 4'b1111;
      default: be_in = 4'b0000;
    endcase
    case (size_in)
      2'b00:   wdata_in = {4{wdata[7:0]}};
      2'b01:   wdata_in = {2{wdata[15:0]}};
      default: wdata_in = wdata;
    endcase
  end

  // Lane selection and extension of the returned word
  logic [DATA_W-1:0] shifted, ext;

  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   ext = uns_q ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                           : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      2'b01:   ext = uns_q ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                           : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // A misaligned op with the exception enabled skips memory and reports in DONE
          state_d = (misal_in && MisalExc) ? StDone : StAccess;
        end
      end
      StAccess: begin
        if (mem_ack) state_d = we_q ? StIdle : StDone;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      miss_q  <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= op[3];
        uns_q   <= op[2];
        miss_q  <= misal_in && MisalExc;
        size_q  <= size_in;
        lane_q  <= lane_in;
        be_q    <= be_in;
        addr_q  <= {addr[ADDR_W-1:2], 2'b00};
        wdata_q <= wdata_in;
      end
      if ((state_q == StAccess) && mem_ack && !we_q) rdata_q <= ext;
    end
  end

  logic access;

  always_comb begin
    access    = (state_q == StAccess);
    req_ready = (state_q == StIdle);
    stall     = (state_q != StIdle);
    // Port fields are zero outside ACCESS, so reset drops the request at once
    mem_req   = access;
    mem_we    = access && we_q;
    mem_addr  = access ? addr_q : '0;
    mem_be    = access ? be_q : 4'b0000;
    mem_wdata = access ? wdata_q : '0;
    rd_valid  = (state_q == StDone) && !miss_q;
    rdata     = rdata_q;
  end

`ifdef LSU_MISALIGN_EXC_EN
  assign misalign = (state_q == StDone) && miss_q;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  op;
  logic [31:0] addr, wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rd_valid, stall;
  logic [31:0] rdata;
`ifdef LSU_MISALIGN_EXC_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rd_valid  (rd_valid),
    .rdata     (rdata),
    .stall     (stall)
`ifdef LSU_MISALIGN_EXC_EN
    ,
    .misalign  (misalign)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: accesses are n = 2^size bytes, placed at the address rounded
  // down to a multiple of n within the word.
  function automatic int m_n(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic int m_off(input logic [31:0] a, input logic [1:0] sz);
    int lo;
    lo = int'(a % 4);
    return lo - (lo % m_n(sz));
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    int v;
    v = ((1 << m_n(sz)) - 1) << m_off(a, sz);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % m_n(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] rd, input logic [31:0] a,
                                          input logic [1:0] sz, input logic uns);
    longint unsigned v, mask;
    int bits;
    v = 64'(rd) >> (8 * m_off(a, sz));
    bits = 8 * m_n(sz);
    if (bits < 32) begin
      mask = (64'd1 << bits) - 1;
      v = v & mask;
      if (!uns && v[bits-1]) v = v | (~mask);
    end
    return v[31:0];
  endfunction

  function automatic bit m_misal(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'b01 || sz == 2'b10) && ((a % m_n(sz)) != 0);
  endfunction

  // Runs one op through the unit with a memory answering after dly wait cycles
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int dly, input logic [3:0] ebe,
                       input logic [31:0] emaddr, input logic [31:0] emwd,
                       input logic [31:0] erd, input string nm);
    chk({nm, " req_ready idle"}, req_ready, 1'b1);
    req_valid = 1'b1; op = o; addr = a; wdata = wd;
    step();
    req_valid = 1'b0; op = $urandom; addr = $urandom; wdata = $urandom;
    if (o[1:0] == 2'b11) begin
      chk({nm, " inv mem_req"}, mem_req, 1'b0);
      chk({nm, " inv req_ready"}, req_ready, 1'b1);
      chk({nm, " inv rd_valid"}, rd_valid, 1'b0);
      return;
    end
`ifdef LSU_MISALIGN_EXC_EN
    if (m_misal(a, o[1:0])) begin
      chk({nm, " misalign pulse"}, misalign, 1'b1);
      chk({nm, " misalign mem_req"}, mem_req, 1'b0);
      chk({nm, " misalign rd_valid"}, rd_valid, 1'b0);
      step();
      chk({nm, " misalign end"}, misalign, 1'b0);
      chk({nm, " misalign ready"}, req_ready, 1'b1);
      chk({nm, " misalign mem_req2"}, mem_req, 1'b0);
      return;
    end
`endif
    for (int c = 0; c <= dly; c++) begin
      chk({nm, " mem_req"}, mem_req, 1'b1);
      chk({nm, " mem_we"}, mem_we, o[3]);
      chk({nm, " mem_addr"}, mem_addr, emaddr);
      chk({nm, " mem_be"}, mem_be, ebe);
      chk({nm, " mem_wdata"}, mem_wdata, emwd);
      chk({nm, " stall"}, stall, 1'b1);
      chk({nm, " busy ready"}, req_ready, 1'b0);
      if (c == dly) begin
        mem_ack = 1'b1;
        mem_rdata = rd;
      end
      step();
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
    if (o[3]) begin
      chk({nm, " st ready"}, req_ready, 1'b1);
      chk({nm, " st rd_valid"}, rd_valid, 1'b0);
      chk({nm, " st mem_req"}, mem_req, 1'b0);
      chk({nm, " st rdata held"}, rdata, last_rd);
    end else begin
      chk({nm, " ld rd_valid"}, rd_valid, 1'b1);
      chk({nm, " ld rdata"}, rdata, erd);
      chk({nm, " ld ready"}, req_ready, 1'b0);
      last_rd = erd;
      step();
      chk({nm, " ld pulse end"}, rd_valid, 1'b0);
      chk({nm, " ld ready back"}, req_ready, 1'b1);
      chk({nm, " ld rdata held"}, rdata, erd);
    end
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [31:0] a, wd, rd;
    int          dly;
    logic [3:0]  ebe;
    logic [31:0] emaddr, emwd, erd;
    string       nm;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // {op, addr, wdata, mem_rdata, ack delay, be, mem_addr, mem_wdata, rdata, name}
    tbl[0] = '{4'b1010, 32'h1004, 32'hDEADBEEF, 32'h0, 3, 4'hF, 32'h1004, 32'hDEADBEEF,
               32'h0, "SW"};
    tbl[1] = '{4'b1000, 32'h2003, 32'h000000A5, 32'h0, 0, 4'h8, 32'h2000, 32'hA5A5A5A5,
               32'h0, "SB"};
    tbl[2] = '{4'b0000, 32'h2002, 32'h0, 32'h12803456, 0, 4'h4, 32'h2000, 32'h0,
               32'hFFFFFF80, "LB"};
    tbl[3] = '{4'b0100, 32'h2002, 32'h0, 32'h12803456, 0, 4'h4, 32'h2000, 32'h0,
               32'h00000080, "LBU"};
    tbl[4] = '{4'b0001, 32'h2002, 32'h0, 32'h80017FFF, 1, 4'hC, 32'h2000, 32'h0,
               32'hFFFF8001, "LH"};
    tbl[5] = '{4'b0101, 32'h2002, 32'h0, 32'h80017FFF, 0, 4'hC, 32'h2000, 32'h0,
               32'h00008001, "LHU"};
    tbl[6] = '{4'b0010, 32'h3001, 32'h0, 32'h11223344, 1, 4'hF, 32'h3000, 32'h0,
               32'h11223344, "LW misal"};
    tbl[7] = '{4'b1001, 32'h4002, 32'h12345678, 32'h0, 2, 4'hC, 32'h4000, 32'h56785678,
               32'h0, "SH"};
    tbl[8] = '{4'b0011, 32'h5000, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0, "INV"};
    tbl[9] = '{4'b0001, 32'h2003, 32'h0, 32'h80017FFF, 0, 4'hC, 32'h2000, 32'h0,
               32'hFFFF8001, "LH misal"};

    reset_n = 1'b0; req_valid = 1'b0; op = 4'h0; addr = 32'h0; wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #12;
    chk("reset req_ready", req_ready, 1'b1);
    chk("reset mem_req", mem_req, 1'b0);
    chk("reset stall", stall, 1'b0);
    chk("reset rd_valid", rd_valid, 1'b0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset mem_be", mem_be, 4'h0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].o, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].dly, tbl[i].ebe,
            tbl[i].emaddr, tbl[i].emwd, tbl[i].erd, tbl[i].nm);
    end

    // Reset while a load is waiting for its ack
    req_valid = 1'b1; op = 4'b0010; addr = 32'h6000;
    step();
    req_valid = 1'b0;
    step();
    chk("rst mid mem_req before", mem_req, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst mid mem_req", mem_req, 1'b0);
    chk("rst mid stall", stall, 1'b0);
    chk("rst mid req_ready", req_ready, 1'b1);
    step();
    reset_n = 1'b1;
    last_rd = 32'h0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    chk("rst late ack rd_valid", rd_valid, 1'b0);
    chk("rst late ack mem_req", mem_req, 1'b0);
    chk("rst late ack rdata", rdata, 32'h0);
    step();
    chk("rst late ack rd_valid2", rd_valid, 1'b0);

    // Random ops against the model
    for (int i = 0; i < 200; i++) begin
      logic [3:0]  o;
      logic [31:0] a, wd, rd;
      int          dly;
      o = 4'($urandom);
      a = $urandom;
      wd = $urandom;
      rd = $urandom;
      dly = $urandom_range(0, 3);
      do_op(o, a, wd, rd, dly, m_be(a, o[1:0]), {a[31:2], 2'b00}, m_wdata(wd, o[1:0]),
            m_rdata(rd, a, o[1:0], o[2]), "rand");
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
